// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyphs, nibble codes and scan state for the 7-segment display path
package seg7_pkg;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [3:0] CODE_BLANK = 4'hA;
    localparam logic [3:0] CODE_MINUS = 4'hB;
    typedef enum logic {BLANK, DRIVE} state_t;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: nibble to active-low {g,f,e,d,c,b,a} glyph
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    always_comb begin
        case (nib)
            4'h0:       seg = SEG_0;
            4'h1:       seg = SEG_1;
            4'h2:       seg = SEG_2;
            4'h3:       seg = SEG_3;
            4'h4:       seg = SEG_4;
            4'h5:       seg = SEG_5;
            4'h6:       seg = SEG_6;
            4'h7:       seg = SEG_7;
            4'h8:       seg = SEG_8;
            4'h9:       seg = SEG_9;
            CODE_MINUS: seg = SEG_MINUS;
            default:    seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: frame-latched 4-digit common-anode scan with ghost blanking and leading-zero suppression
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int SCAN_FREQ    = 1000,
    parameter int GHOST_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);
    localparam int DIV = CLK_FREQ / SCAN_FREQ;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
    localparam logic [CW-1:0] GH_LAST = CW'(GHOST_CYCLES - 1);

    logic [CW-1:0] cyc;
    logic [1:0]    slot_idx;
    state_t        state;
    logic [15:0]   snap_digits;
    logic [3:0]    snap_dp;
    logic          snap_lz;
    logic          sup3, sup2, sup1;
    logic [3:0]    sup;
    logic [3:0]    shown;
    logic [6:0]    glyph;
    logic          new_frame;

    // suppression ripples right from digit 3; a blank code above counts as already suppressed
    assign sup3 = snap_lz && snap_digits[15:12] == 4'h0;
    assign sup2 = snap_lz && snap_digits[11:8] == 4'h0 && (sup3 || snap_digits[15:12] == CODE_BLANK);
    assign sup1 = snap_lz && snap_digits[7:4] == 4'h0 && (sup2 || snap_digits[11:8] == CODE_BLANK);
    assign sup  = {sup3, sup2, sup1, 1'b0};

    assign shown     = sup[slot_idx] ? CODE_BLANK : snap_digits[{slot_idx, 2'b00} +: 4];
    assign new_frame = cyc == '0 && slot_idx == 2'd0;

    seg7_decode u_decode (.nib(shown), .seg(glyph));

    // state always describes the cycle that cyc currently indexes
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc         <= '0;
            slot_idx    <= 2'd0;
            state       <= BLANK;
            snap_digits <= 16'hAAAA;
            snap_dp     <= 4'h0;
            snap_lz     <= 1'b0;
            an          <= 4'hF;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            cyc         <= cyc == LAST ? '0 : cyc + 1'b1;
            slot_idx    <= cyc == LAST ? slot_idx + 2'd1 : slot_idx;
            state       <= cyc == LAST ? BLANK : cyc == GH_LAST ? DRIVE : state;
            snap_digits <= new_frame ? digits_in : snap_digits;
            snap_dp     <= new_frame ? dp_in : snap_dp;
            snap_lz     <= new_frame ? lz_en : snap_lz;
            frame_start <= new_frame;
            an          <= state == DRIVE ? ~(4'b0001 << slot_idx) : 4'hF;
            seg         <= state == DRIVE ? glyph : SEG_BLANK;
            dp          <= state == DRIVE ? ~(snap_dp[slot_idx] & ~sup[slot_idx]) : 1'b1;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed frame-by-frame checks of the scan driver with DIV=8, GHOST_CYCLES=2
module tb_seg7_scan_driver;
    localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30, G4 = 7'h19;
    localparam logic [6:0] G5 = 7'h12, G9 = 7'h10, GB = 7'h7F, GM = 7'h3F;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;
    int          checks = 0;
    int          failures = 0;

    seg7_scan_driver #(.CLK_FREQ(16), .SCAN_FREQ(2), .GHOST_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .lz_en(lz_en),
        .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        checks++;
        assert ($countones(~an) <= 1) else begin
            failures++;
            $error("FAIL one_hot_an got=%b exp=at_most_one_low", an);
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // walks one 32-cycle frame; optionally changes digits_in before absolute cycle chg_at
    task automatic frame(input string tag, input logic [6:0] e0, e1, e2, e3,
                         input logic [3:0] dpx, input int chg_at, input logic [15:0] chg_val);
        logic [6:0] es [4];
        es = '{e0, e1, e2, e3};
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 8; c++) begin
                if (s * 8 + c == chg_at) digits_in = chg_val;
                step();
                chk({tag, "_fs"}, 16'(frame_start), 16'(s == 0 && c == 0));
                if (c < 2) begin
                    chk({tag, "_ghost_an"}, 16'(an), 16'hF);
                    chk({tag, "_ghost_seg"}, 16'(seg), 16'(GB));
                end else begin
                    chk({tag, "_an"}, 16'(an), 16'(~(4'b0001 << s) & 4'hF));
                    chk({tag, "_seg"}, 16'(seg), 16'(es[s]));
                    chk({tag, "_dp"}, 16'(dp), 16'(dpx[s]));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        digits_in = 16'h1234;
        dp_in = 4'h0;
        lz_en = 1'b0;
        step();
        step();
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_seg", 16'(seg), 16'(GB));
        chk("rst_dp", 16'(dp), 16'h1);
        chk("rst_fs", 16'(frame_start), 16'h0);
        rst = 1'b0;
        frame("f1234", G4, G3, G2, G1, 4'hF, -1, 16'h0);

        digits_in = 16'h0050;
        dp_in = 4'b1100;
        lz_en = 1'b1;
        frame("lz_on", G0, G5, GB, GB, 4'hF, -1, 16'h0);
        lz_en = 1'b0;
        frame("lz_off", G0, G5, G0, G0, 4'b0011, -1, 16'h0);

        digits_in = 16'h1111;
        dp_in = 4'h0;
        frame("tear_old", G1, G1, G1, G1, 4'hF, 10, 16'h2222);
        frame("tear_new", G2, G2, G2, G2, 4'hF, -1, 16'h0);

        digits_in = 16'hAB9A;
        dp_in = 4'b0100;
        frame("codes", GB, G9, GM, GB, 4'b1011, -1, 16'h0);

        digits_in = 16'h1234;
        dp_in = 4'h0;
        for (int k = 0; k < 21; k++) step();
        chk("mid_an", 16'(an), 16'hB);
        chk("mid_seg", 16'(seg), 16'(G2));
        rst = 1'b1;
        step();
        chk("mrst_an", 16'(an), 16'hF);
        chk("mrst_seg", 16'(seg), 16'(GB));
        chk("mrst_dp", 16'(dp), 16'h1);
        chk("mrst_fs", 16'(frame_start), 16'h0);
        rst = 1'b0;
        digits_in = 16'h0B34;
        frame("restart", G4, G3, GM, G0, 4'hF, -1, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Consumer end of the 16-bit display-digit bus that the digit producers and output modifiers (e.g. flicker) drive. It latches a four-nibble digit word once per frame and time-multiplexes it onto a common-anode 4-digit 7-segment display. Blank-slot ghost suppression and optional leading-zero suppression are included. It sits between the last output modifier and the board pins.

## Interface
- CLK_FREQ, 50_000_000 — input clock frequency, Hz
- SCAN_FREQ, 1000 — digit-slot rate, Hz; DIV = CLK_FREQ/SCAN_FREQ cycles per slot; DIV ≥ 4 required
- GHOST_CYCLES, 500 — cycles at start of each slot with all anodes off; 1 ≤ GHOST_CYCLES < DIV
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- digits_in  in  16  nibble i = digits_in[4i+3:4i] feeds digit i; digit 0 is rightmost
- dp_in  in  4  decimal point request per digit, active-high
- lz_en  in  1  enable leading-zero suppression
- an  out  4  anode enables, active-low; an[i] drives digit i
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- frame_start  out  1  one-cycle pulse when the snapshot is taken

## Operation
- Nibble decode: 0–9 give standard glyphs. 4'hA gives blank (seg=7'h7F), matching the bus blank code. 4'hB gives minus (only g lit, seg=7'h3F). 4'hC–4'hF give blank.
- Snapshot: digits_in, dp_in and lz_en are registered together at the start of slot 0. Changes mid-frame are ignored until the next frame, so there is no tearing.
- Leading-zero suppression, applied to the snapshot when lz_en=1:
  - Digit 3 is blanked if its nibble is 0.
  - Digit k (k=2,1) is blanked if its nibble is 0 and digit k+1 was blanked or holds 4'hA.
  - Digit 0 is never suppressed.
  - A suppressed digit also forces its dp off.
- Two states per slot:
  - BLANK: an=4'hF, seg=7'h7F, dp=1.
  - DRIVE: an has a single 0 at bit slot_idx; seg and dp come from the decoded snapshot nibble slot_idx.
- Transitions:
  - BLANK → DRIVE when cyc == GHOST_CYCLES−1.
  - DRIVE → BLANK when cyc == DIV−1; at the same time slot_idx increments mod 4.
- Counters:
  - cyc is a $clog2(DIV)-bit counter, wrapping DIV−1 → 0.
  - slot_idx is 2 bits, wrapping 3 → 0.
  - Wrap of slot_idx to 0 starts a new frame.
- Exactly one anode is low during DRIVE. More than one anode is never low in any cycle.

## Timing
- Reset values, held while rst=1: an=4'hF, seg=7'h7F, dp=1, frame_start=0, cyc=0, slot_idx=0, state=BLANK, snapshot=16'hAAAA, dp snapshot=0, lz snapshot=0.
- The first rising edge with rst=0 is cycle 0 of slot 0. At that edge the snapshot is taken and frame_start=1 for exactly that cycle.
- All outputs are registered; values described for cycle k appear after edge k.
  - Cycles 0..GHOST_CYCLES−1 of a slot: blank outputs.
  - Cycles GHOST_CYCLES..DIV−1: driven outputs.
- Frame period is 4·DIV cycles. frame_start pulses every 4·DIV cycles.
- Latency from digits_in change to display is at most 4·DIV + GHOST_CYCLES cycles.
- rst asserted mid-slot: outputs go to reset values on that edge. The scan restarts from slot 0 with a fresh snapshot on the first edge after release.

## Structure
- Shared package seg7_pkg holds:
  - segment glyph constants SEG_0..SEG_9, SEG_BLANK=7'h7F, SEG_MINUS=7'h3F
  - nibble codes CODE_BLANK=4'hA, CODE_MINUS=4'hB
  - the state enum {BLANK, DRIVE}
- Sub-module seg7_decode: purely combinational nibble → 7-bit active-low glyph, instantiated once on the muxed nibble.
- Top level holds the counters, the state register, the snapshot register, LZ logic and the output registers.

## Test plan
All scenarios use CLK_FREQ=16, SCAN_FREQ=2 (DIV=8), GHOST_CYCLES=2.
- Reset then digits_in=16'h1234, lz_en=0:
  - Slot 0 cycles 2–7: an=4'b1110, seg=SEG_4.
  - Slot 3: an=4'b0111, seg=SEG_1.
  - Cycles 0–1 of every slot: an=4'hF.
- digits_in=16'h0050, lz_en=1:
  - Digits 3 and 2 are blank (an asserted, seg=7'h7F).
  - Digit 1 shows SEG_5 and digit 0 shows SEG_0.
  - With lz_en=0, digit 3 shows SEG_0.
- digits_in changes 16'h1111 → 16'h2222 at cycle 10 (slot 1):
  - Slots 1–3 still show SEG_1.
  - The switch to 2 occurs at cycle 32, coinciding with frame_start=1.
- digits_in=16'hAB9A, dp_in=4'b0100:
  - Digit 0 is blank.
  - Digit 1 shows SEG_9 with dp=1.
  - Digit 2 shows minus with dp=0.
  - Digit 3 is blank.
- rst asserted at cycle 21 for 1 cycle:
  - Outputs are at reset values after that edge.
  - frame_start=1 on the first post-release edge.
  - Slot 0 restarts.
- Invariant checked every cycle: popcount(~an) ≤ 1, and popcount(~an)=0 in BLANK.
